// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: one cycle from decode inputs to ex_* outputs; stall_id is combinational.
// Backpressure: stall_id holds decode/fetch for one cycle while a bubble is loaded into EX.
module id_ex_stage #(
    parameter int          DATA_W    = 32,
    parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [1:0]        ALUout_in,
    input  logic              MemR_in,
    input  logic              MemW_in,
    input  logic              RegW_in,
    input  logic              MemToReg_in,
    input  logic              aluSrc_in,
    input  logic              regDest_in,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm,
    input  logic [5:0]        funct,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic              flush,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUout,
    output logic              ex_MemR,
    output logic              ex_MemW,
    output logic              ex_RegW,
    output logic              ex_MemToReg,
    output logic              ex_aluSrc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [5:0]        ex_funct,
    output logic [4:0]        ex_rt_addr,
    output logic [4:0]        ex_dest,
    output logic              stall_id,
    output logic [15:0]       stall_cnt
);

    logic              r_valid;
    logic [1:0]        r_alu;
    logic              r_memr;
    logic              r_memw;
    logic              r_regw;
    logic              r_mem2reg;
    logic              r_alusrc;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [5:0]        r_funct;
    logic [4:0]        r_rt_addr;
    logic [4:0]        r_dest;
    logic [15:0]       r_stall_cnt;

    logic              w_stall;
    logic              w_load;
    logic [4:0]        w_dest;
    logic [DATA_W-1:0] w_imm_sext;

    // A load writing $0 never produces a value, so it can never cause a hazard.
    assign w_stall = in_valid & r_valid & r_memr & (r_rt_addr != 5'd0) &
                     ((r_rt_addr == rs_addr) | (r_rt_addr == rt_addr));

    assign w_load     = in_valid & ~flush & ~w_stall;
    assign w_dest     = regDest_in ? rt_addr : rd_addr;
    assign w_imm_sext = {{(DATA_W-16){imm[15]}}, imm};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_alu     <= 2'b00;
            r_memr    <= 1'b0;
            r_memw    <= 1'b0;
            r_regw    <= 1'b0;
            r_mem2reg <= 1'b0;
            r_alusrc  <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_funct   <= 6'd0;
            r_rt_addr <= 5'd0;
            r_dest    <= 5'd0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_alu     <= ALUout_in;
            r_memr    <= MemR_in;
            r_memw    <= MemW_in;
            r_regw    <= RegW_in;
            r_mem2reg <= MemToReg_in;
            r_alusrc  <= aluSrc_in;
            r_rs_data <= rs_data;
            r_rt_data <= rt_data;
            r_imm     <= w_imm_sext;
            r_funct   <= funct;
            r_rt_addr <= rt_addr;
            r_dest    <= w_dest;
        end else begin
            // Bubble: clearing r_valid also releases stall_id on the next cycle.
            r_valid   <= 1'b0;
            r_alu     <= 2'b00;
            r_memr    <= 1'b0;
            r_memw    <= 1'b0;
            r_regw    <= 1'b0;
            r_mem2reg <= 1'b0;
            r_alusrc  <= 1'b0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_funct   <= 6'd0;
            r_rt_addr <= 5'd0;
            r_dest    <= 5'd0;
        end
    end

    // Flushed cycles kill the bubble's cause too, so they are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && !flush && (r_stall_cnt != STALL_SAT)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_ALUout   = r_alu;
    assign ex_MemR     = r_memr;
    assign ex_MemW     = r_memw;
    assign ex_RegW     = r_regw;
    assign ex_MemToReg = r_mem2reg;
    assign ex_aluSrc   = r_alusrc;
    assign ex_rs_data  = r_rs_data;
    assign ex_rt_data  = r_rt_data;
    assign ex_imm      = r_imm;
    assign ex_funct    = r_funct;
    assign ex_rt_addr  = r_rt_addr;
    assign ex_dest     = r_dest;
    assign stall_id    = w_stall;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus reset and saturation sequences.
module tb_id_ex_stage;

    localparam logic [15:0] SAT = 16'd300;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, flush;
    logic [1:0]  ALUout_in;
    logic        MemR_in, MemW_in, RegW_in, MemToReg_in, aluSrc_in, regDest_in;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        ex_valid, ex_MemR, ex_MemW, ex_RegW, ex_MemToReg, ex_aluSrc, stall_id;
    logic [1:0]  ex_ALUout;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_rt_addr, ex_dest;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .STALL_SAT(SAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .ALUout_in(ALUout_in), .MemR_in(MemR_in), .MemW_in(MemW_in), .RegW_in(RegW_in),
        .MemToReg_in(MemToReg_in), .aluSrc_in(aluSrc_in), .regDest_in(regDest_in),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .funct(funct),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .flush(flush),
        .ex_valid(ex_valid), .ex_ALUout(ex_ALUout), .ex_MemR(ex_MemR), .ex_MemW(ex_MemW),
        .ex_RegW(ex_RegW), .ex_MemToReg(ex_MemToReg), .ex_aluSrc(ex_aluSrc),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_funct(ex_funct), .ex_rt_addr(ex_rt_addr), .ex_dest(ex_dest),
        .stall_id(stall_id), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        iv, fl;
        logic [1:0]  alu;
        logic        mr, mw, rw, rdsel;
        logic [31:0] rsd;
        logic [15:0] imm;
        logic [4:0]  rs, rt, rd;
        logic        x_stall, x_valid;
        logic [1:0]  x_alu;
        logic        x_mr, x_mw, x_rw;
        logic [4:0]  x_dest;
        logic [31:0] x_rsd, x_imm;
        logic [15:0] x_cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        logic iv, logic fl, logic [1:0] alu, logic mr, logic mw, logic rw, logic rdsel,
        logic [31:0] rsd, logic [15:0] im, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
        logic x_stall, logic x_valid, logic [1:0] x_alu, logic x_mr, logic x_mw, logic x_rw,
        logic [4:0] x_dest, logic [31:0] x_rsd, logic [31:0] x_imm, logic [15:0] x_cnt);
        vec_t v;
        v.iv = iv; v.fl = fl; v.alu = alu; v.mr = mr; v.mw = mw; v.rw = rw; v.rdsel = rdsel;
        v.rsd = rsd; v.imm = im; v.rs = rs; v.rt = rt; v.rd = rd;
        v.x_stall = x_stall; v.x_valid = x_valid; v.x_alu = x_alu; v.x_mr = x_mr;
        v.x_mw = x_mw; v.x_rw = x_rw; v.x_dest = x_dest; v.x_rsd = x_rsd;
        v.x_imm = x_imm; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // MemToReg, aluSrc, rt_data and funct are derived from the other fields.
    task automatic drive(input vec_t v);
        in_valid    = v.iv;
        flush       = v.fl;
        ALUout_in   = v.alu;
        MemR_in     = v.mr;
        MemW_in     = v.mw;
        RegW_in     = v.rw;
        MemToReg_in = v.mr;
        aluSrc_in   = v.mr | v.mw;
        regDest_in  = v.rdsel;
        rs_data     = v.rsd;
        rt_data     = v.rsd + 32'd1;
        imm         = v.imm;
        funct       = v.imm[5:0];
        rs_addr     = v.rs;
        rt_addr     = v.rt;
        rd_addr     = v.rd;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, " ctrl"}, {25'd0, ex_ALUout, ex_MemR, ex_MemW, ex_RegW, ex_MemToReg, ex_aluSrc}, 32'd0);
        chk({tag, " rs_data"}, ex_rs_data, 32'd0);
        chk({tag, " rt_data"}, ex_rt_data, 32'd0);
        chk({tag, " imm"}, ex_imm, 32'd0);
        chk({tag, " fields"}, {16'd0, ex_funct, ex_rt_addr, ex_dest}, 32'd0);
        chk({tag, " stall_id"}, {31'd0, stall_id}, 32'd0);
        chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    endtask

    initial begin
        vec_t lw;
        vecs[0]  = mk(1,0,2'b10,0,0,1,0, 32'h5,   16'h0020, 3, 8, 9,  0,1,2'b10,0,0,1, 9, 32'h5,   32'h00000020, 0);
        vecs[1]  = mk(1,0,2'b00,1,0,1,1, 32'h100, 16'h0004, 3, 8, 0,  0,1,2'b00,1,0,1, 8, 32'h100, 32'h00000004, 0);
        vecs[2]  = mk(1,0,2'b10,0,0,1,0, 32'h11,  16'h0000, 8, 4, 10, 1,0,2'b00,0,0,0, 0, 32'h0,   32'h0,        1);
        vecs[3]  = mk(1,0,2'b10,0,0,1,0, 32'h11,  16'h0000, 8, 4, 10, 0,1,2'b10,0,0,1, 10,32'h11,  32'h0,        1);
        vecs[4]  = mk(1,0,2'b00,1,0,1,1, 32'h22,  16'h8000, 2, 0, 0,  0,1,2'b00,1,0,1, 0, 32'h22,  32'hFFFF8000, 1);
        vecs[5]  = mk(1,0,2'b10,0,0,1,0, 32'h33,  16'h7FFF, 0, 0, 5,  0,1,2'b10,0,0,1, 5, 32'h33,  32'h00007FFF, 1);
        vecs[6]  = mk(1,0,2'b00,1,0,1,1, 32'h44,  16'h0008, 1, 6, 0,  0,1,2'b00,1,0,1, 6, 32'h44,  32'h00000008, 1);
        vecs[7]  = mk(1,1,2'b10,0,0,1,0, 32'h55,  16'h0000, 2, 6, 11, 1,0,2'b00,0,0,0, 0, 32'h0,   32'h0,        1);
        vecs[8]  = mk(1,0,2'b00,0,1,0,1, 32'h66,  16'hFFFC, 2, 7, 0,  0,1,2'b00,0,1,0, 7, 32'h66,  32'hFFFFFFFC, 1);
        vecs[9]  = mk(0,0,2'b10,1,1,1,1, 32'h77,  16'h1234, 7, 7, 7,  0,0,2'b00,0,0,0, 0, 32'h0,   32'h0,        1);
        vecs[10] = mk(1,0,2'b00,1,0,1,1, 32'h88,  16'h0010, 5, 12,0,  0,1,2'b00,1,0,1, 12,32'h88,  32'h00000010, 1);
        vecs[11] = mk(0,0,2'b10,0,0,1,0, 32'h99,  16'h0000, 12,12,13, 0,0,2'b00,0,0,0, 0, 32'h0,   32'h0,        1);
        vecs[12] = mk(1,0,2'b00,1,0,1,1, 32'hAA,  16'h0001, 5, 13,0,  0,1,2'b00,1,0,1, 13,32'hAA,  32'h00000001, 1);
        vecs[13] = mk(1,0,2'b10,0,0,1,0, 32'hBB,  16'h0000, 1, 13,14, 1,0,2'b00,0,0,0, 0, 32'h0,   32'h0,        2);
        vecs[14] = mk(1,0,2'b10,0,0,1,0, 32'hBB,  16'h0000, 1, 13,14, 0,1,2'b10,0,0,1, 14,32'hBB,  32'h0,        2);

        // Async reset with a hazard-shaped input pattern, before any clock edge.
        rst = 1'b1;
        drive(vecs[2]);
        #2;
        chk_zero("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d stall_id", i), {31'd0, stall_id}, {31'd0, vecs[i].x_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].x_valid});
            chk($sformatf("v%0d ctrl", i), {27'd0, ex_ALUout, ex_MemR, ex_MemW, ex_RegW},
                {27'd0, vecs[i].x_alu, vecs[i].x_mr, vecs[i].x_mw, vecs[i].x_rw});
            chk($sformatf("v%0d m2r_src", i), {30'd0, ex_MemToReg, ex_aluSrc},
                {30'd0, vecs[i].x_mr, vecs[i].x_valid & (vecs[i].x_mr | vecs[i].x_mw)});
            chk($sformatf("v%0d dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].x_dest});
            chk($sformatf("v%0d rt_addr", i), {27'd0, ex_rt_addr}, vecs[i].x_valid ? {27'd0, vecs[i].rt} : 32'd0);
            chk($sformatf("v%0d rs_data", i), ex_rs_data, vecs[i].x_rsd);
            chk($sformatf("v%0d rt_data", i), ex_rt_data, vecs[i].x_valid ? vecs[i].rsd + 32'd1 : 32'd0);
            chk($sformatf("v%0d imm", i), ex_imm, vecs[i].x_imm);
            chk($sformatf("v%0d funct", i), {26'd0, ex_funct}, vecs[i].x_valid ? {26'd0, vecs[i].imm[5:0]} : 32'd0);
            chk($sformatf("v%0d stall_cnt", i), {16'd0, stall_cnt}, {16'd0, vecs[i].x_cnt});
        end

        // Mid-cycle reset discards the valid instruction sitting in EX.
        drive(vecs[1]);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst valid", {31'd0, ex_valid}, 32'd1);
        chk("post_rst dest", {27'd0, ex_dest}, 32'd8);
        chk("post_rst cnt", {16'd0, stall_cnt}, 32'd0);

        // Self-dependent load every cycle: one stall per two edges.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        lw = mk(1,0,2'b00,1,0,1,1, 32'h1, 16'h0, 8, 8, 0, 0,0,2'b00,0,0,0, 0, 32'h0, 32'h0, 0);
        drive(lw);
        for (int k = 0; k < 2 * int'(SAT) - 2; k++) begin
            @(posedge clk);
        end
        #1;
        chk("sat pre", {16'd0, stall_cnt}, {16'd0, SAT - 16'd1});
        @(posedge clk);
        #1;
        chk("sat stall_id", {31'd0, stall_id}, 32'd1);
        @(posedge clk);
        #1;
        chk("sat reach", {16'd0, stall_cnt}, {16'd0, SAT});
        @(posedge clk);
        #1;
        chk("sat stall_id again", {31'd0, stall_id}, 32'd1);
        @(posedge clk);
        #1;
        chk("sat hold", {16'd0, stall_cnt}, {16'd0, SAT});
        chk("sat bubble", {31'd0, ex_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
